mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-store bus (`data_write`, `data`, `data_address`), which has no backpressure.
- A store-byte to `BASE_ADDR` pushes the byte into a small FIFO.
- An FSM serializes queued bytes as 8N1 frames on `tx`, LSB first.
- This is the console/debug output path for programs running on the pipelined core.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, full 32-bit byte address of the TX data register.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be ≥ 2.
- FIFO_DEPTH, 8, number of FIFO entries. Must be a power of 2 and ≥ 2.
- DROP_W, 8, width of the dropped-byte counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_write  input  1  CPU store strobe, one cycle per store.
- data  input  8  store data, low byte.
- data_address  input  32  store byte address.
- tx  output  1  serial line; idles high.
- busy  output  1  1 while a frame is on the line (START, DATA or STOP state).
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  DROP_W  saturating count of discarded stores.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, drop_count=0.
  - FSM goes to IDLE; FIFO pointers cleared; bit/baud counters cleared.
  - In-flight and queued bytes are lost.
- Address decode: a store is "hit" when data_write=1 and data_address==BASE_ADDR (exact 32-bit compare), sampled at the rising edge. All other stores are ignored with no side effects.
- Push: a hit is written to the FIFO tail if fifo_count<FIFO_DEPTH, or if a pop occurs at the same edge. Otherwise the byte is discarded and drop_count increments, saturating at all-ones.
- Pop: occurs at the edge where the FSM leaves IDLE or STOP into START with fifo_count>0 (count sampled before the edge). The head byte loads into the shift register.
  - Push and pop at the same edge leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO flags derive from registered fifo_count only; no combinational path from inputs.
- FSM states:
  - IDLE: tx=1. If fifo_count>0, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if fifo_count>0, pop and go straight to START (no idle gap); else go to IDLE.
- tx is a registered output driven from state/shift register; it is glitch-free.
- Latency:
  - A hit sampled at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1; tx falls after edge k+1.
  - One frame lasts exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state/bit transition.
- Capacity under a continuous burst while idle: 1 byte in the shifter plus FIFO_DEPTH bytes queued.

Test Plan:
- CLKS_PER_BIT=4, store 0x55 to BASE_ADDR from idle:
  - tx falls 1 cycle after the write edge.
  - Line pattern is 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 cycles each, 40 cycles total.
  - busy=1 for exactly 40 cycles; fifo_count returns to 0 after the pop edge.
- Store 0xA3 to BASE_ADDR+1, and assert data_write=0 with data_address=BASE_ADDR:
  - tx stays 1, fifo_count=0, drop_count=0.
- Three consecutive-cycle stores 0x01, 0x02, 0x03:
  - Three frames back-to-back, 120 cycles with no high gap beyond each stop bit.
  - Decoded bytes arrive in order.
- FIFO_DEPTH=8, ten consecutive-cycle hits while idle:
  - First byte is popped immediately.
  - fifo_full=1 after the 9th write; 10th is dropped, drop_count=1.
  - All 9 accepted bytes transmit in order.
- DROP_W=2, keep FIFO full and issue 5 extra hits: drop_count saturates at 3.
- Assert reset during DATA bit 3 of a frame with 4 bytes queued:
  - tx=1 and busy=0 immediately (asynchronously); fifo_count=0.
  - After release, no further frames; a new store transmits normally.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter fed by a store-side byte FIFO
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          DROP_W       = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        data_write,
   input  logic [7:0]                  data,
   input  logic [31:0]                 data_address,
   output logic                        tx,
   output logic                        busy,
   output logic                        fifo_empty,
   output logic                        fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [DROP_W-1:0]           drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift, shift_n;
   logic          tx_n, busy_n;
   logic          baud_last;
   logic          hit, push, pop, drop;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign hit        = data_write && (data_address == BASE_ADDR);
   assign push       = hit && ((fifo_count != DEPTH_C) || pop);
   assign drop       = hit && !push;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == DEPTH_C);

   // State register: FSM, baud/bit counters, shifter and the registered line outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
         if (state != DATA)
            bit_idx <= '0;
         else if (baud_last)
            bit_idx <= bit_idx + 3'd1;
         shift    <= shift_n;
         tx       <= tx_n;
         busy     <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      baud_last = (baud_cnt == BAUD_MAX);
      case (state)
         IDLE:
            if (fifo_count != '0) begin
               state_n = START;
               pop     = 1'b1;
            end
         START:
            if (baud_last) state_n = DATA;
         DATA:
            if (baud_last && bit_idx == 3'd7) state_n = STOP;
         STOP:
            if (baud_last) begin
               if (fifo_count != '0) begin
                  state_n = START;
                  pop     = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         default:
            state_n = IDLE;
      endcase

      shift_n = shift;
      if (pop)
         shift_n = mem[rd_ptr];
      else if (state == DATA && baud_last)
         shift_n = {1'b0, shift[7:1]};
   end

   // Line level is computed from next state so tx leaves a flop, never a mux of flops
   always_comb begin
      busy_n = (state_n != IDLE);
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (drop && drop_count != '1)
            drop_count <= drop_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data;
   end

endmodule
